// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Groups the two requester handshakes and the Memory command/data bus
//   used by mem_arbiter. The clock and reset stay outside the bundle.
//   Requester side : req0/1, wr0/1, addr0/1, wdata0/1 -> arbiter
//                    ack0/1, err, rdata, busy, gnt_id <- arbiter
//   Memory side    : readMem, writeMem, addrBus, memWdata, memWdataEn <- arbiter
//                    rdyMem, outBus -> arbiter
//   Modports: master = arbiter view, slave = requester/memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              gnt_id;
    logic              readMem;
    logic              writeMem;
    logic [ADDR_W-1:0] addrBus;
    logic [DATA_W-1:0] memWdata;
    logic              memWdataEn;
    logic              rdyMem;
    logic [DATA_W-1:0] outBus;

    modport master (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, rdyMem, outBus,
        output ack0, ack1, err, rdata, busy, gnt_id,
               readMem, writeMem, addrBus, memWdata, memWdataEn
    );

    modport slave (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, rdyMem, outBus,
        input  ack0, ack1, err, rdata, busy, gnt_id,
               readMem, writeMem, addrBus, memWdata, memWdataEn
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter and sequencer between two requesters (0 = CPU data
//   port, 1 = fetch/DMA port) and a single-port 256x16 Memory. Each granted
//   transaction issues one readMem/writeMem pulse, holds the address/data
//   until rdyMem, returns read data and pulses the requester's ack. A
//   watchdog closes the transaction with err=1 if rdyMem never arrives.
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : mem_arbiter_if.master (requester handshakes + Memory bus)
// All outputs are registered.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests
// ISSUE | one-cycle command pulse to Memory
// WAIT  | hold bus, wait for rdyMem or watchdog expiry
// DONE  | one-cycle ack (with err) to the granted requester
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 8
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              wr_q, wr_d;
    logic              gnt_id_q, gnt_id_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              read_mem_q, read_mem_d;
    logic              write_mem_q, write_mem_d;
    logic [ADDR_W-1:0] addr_bus_q, addr_bus_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wdata_en_q, mem_wdata_en_d;
    logic              pick1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            last_q         <= 1'b1;  // requester 0 wins the first contention
            wr_q           <= 1'b0;
            gnt_id_q       <= 1'b0;
            cnt_q          <= '0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
            busy_q         <= 1'b0;
            read_mem_q     <= 1'b0;
            write_mem_q    <= 1'b0;
            addr_bus_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wdata_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            wr_q           <= wr_d;
            gnt_id_q       <= gnt_id_d;
            cnt_q          <= cnt_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            err_q          <= err_d;
            rdata_q        <= rdata_d;
            busy_q         <= busy_d;
            read_mem_q     <= read_mem_d;
            write_mem_q    <= write_mem_d;
            addr_bus_q     <= addr_bus_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wdata_en_q <= mem_wdata_en_d;
        end
    end

    // Outputs are registered from the next-state decode, so each pulse
    // lines up with the cycle spent in the corresponding state.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        wr_d           = wr_q;
        gnt_id_d       = gnt_id_q;
        cnt_d          = cnt_q;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        err_d          = 1'b0;
        rdata_d        = rdata_q;
        read_mem_d     = 1'b0;
        write_mem_d    = 1'b0;
        addr_bus_d     = addr_bus_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wdata_en_d = mem_wdata_en_q;
        pick1          = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Under contention the requester that was not served last wins.
                    pick1          = bus.req1 && (!bus.req0 || !last_q);
                    gnt_id_d       = pick1;
                    last_d         = pick1;
                    wr_d           = pick1 ? bus.wr1 : bus.wr0;
                    addr_bus_d     = pick1 ? bus.addr1 : bus.addr0;
                    if (wr_d) begin
                        mem_wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
                    end
                    mem_wdata_en_d = wr_d;
                    read_mem_d     = !wr_d;
                    write_mem_d    = wr_d;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                // Watchdog counts down the WAIT cycles still allowed after this one.
                cnt_d   = TO_W'(TIMEOUT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.rdyMem) begin
                    if (!wr_q) begin
                        rdata_d = bus.outBus;
                    end
                    ack0_d         = !gnt_id_q;
                    ack1_d         = gnt_id_q;
                    mem_wdata_en_d = 1'b0;
                    state_d        = DONE;
                end else if (cnt_q == '0) begin
                    err_d          = 1'b1;
                    ack0_d         = !gnt_id_q;
                    ack1_d         = gnt_id_q;
                    mem_wdata_en_d = 1'b0;
                    state_d        = DONE;
                end else begin
                    cnt_d = cnt_q - TO_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.busy       = busy_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.readMem    = read_mem_q;
    assign bus.writeMem   = write_mem_q;
    assign bus.addrBus    = addr_bus_q;
    assign bus.memWdata   = mem_wdata_q;
    assign bus.memWdataEn = mem_wdata_en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives both requesters and plays the Memory, comparing every completed
//   transaction against a transaction-level model: round-robin winner from
//   the request levels, expected ack latency from the rdyMem delay, and a
//   reference memory image for read data.
module tb_mem_arbiter;
    localparam int AW      = 8;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic          m_last;
    logic [DW-1:0] m_rdata;

    int            cmd_c, ack_c, n_cmd;
    logic          o_ack0, o_ack1, o_err, o_gnt, o_rdc, o_wrc, o_wen;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_rdata;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs one transaction from the current request levels. d = WAIT cycle
    // (1-based) in which rdyMem is raised; d < 1 means Memory never answers.
    task automatic do_txn(input int d);
        cmd_c = -1; ack_c = -1; n_cmd = 0;
        o_ack0 = 0; o_ack1 = 0; o_err = 0; o_gnt = 0; o_rdc = 0; o_wrc = 0; o_wen = 0;
        o_addr = '0; o_wdata = '0; o_rdata = '0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (bif.ack0 || bif.ack1) begin
                ack_c = cyc;
                o_ack0 = bif.ack0; o_ack1 = bif.ack1; o_err = bif.err; o_rdata = bif.rdata;
                if (bif.ack0) bif.req0 = 1'b0;
                if (bif.ack1) bif.req1 = 1'b0;
                bif.rdyMem = 1'b0;
                bif.outBus = DW'($urandom);
                break;
            end
            if (bif.readMem || bif.writeMem) begin
                n_cmd++;
                if (cmd_c < 0) begin
                    cmd_c = cyc;
                    o_gnt = bif.gnt_id; o_rdc = bif.readMem; o_wrc = bif.writeMem;
                    o_addr = bif.addrBus; o_wdata = bif.memWdata; o_wen = bif.memWdataEn;
                    // inputs changing after grant must not matter
                    if (bif.gnt_id) begin
                        bif.addr1 = AW'($urandom); bif.wdata1 = DW'($urandom); bif.wr1 = ~bif.wr1;
                    end else begin
                        bif.addr0 = AW'($urandom); bif.wdata0 = DW'($urandom); bif.wr0 = ~bif.wr0;
                    end
                end
            end
            bif.rdyMem = 1'b0;
            bif.outBus = DW'($urandom);
            if (cmd_c >= 0 && d >= 1 && cyc == cmd_c + d) begin
                if (bif.memWdataEn) mem[bif.addrBus] = bif.memWdata;
                bif.rdyMem = 1'b1;
                bif.outBus = mem[bif.addrBus];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bif.req0 = 0; bif.req1 = 0; bif.wr0 = 0; bif.wr1 = 0;
        bif.addr0 = '0; bif.addr1 = '0; bif.wdata0 = '0; bif.wdata1 = '0;
        bif.rdyMem = 0; bif.outBus = '0;
        step(); step();
        tests++;
        if ({bif.ack0, bif.ack1, bif.err, bif.busy, bif.gnt_id, bif.readMem, bif.writeMem, bif.memWdataEn} !== 8'h00) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {bif.ack0, bif.ack1, bif.err, bif.busy, bif.gnt_id, bif.readMem, bif.writeMem, bif.memWdataEn});
        end
        tests++;
        if ({bif.addrBus, bif.memWdata, bif.rdata} !== '0) begin
            fails++;
            $display("FAIL reset_buses: addr %0h wdata %0h rdata %0h want 0", bif.addrBus, bif.memWdata, bif.rdata);
        end
        rst = 1'b1;
        step(); step();
        tests++;
        if (bif.busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy: got %b want 0", bif.busy);
        end
        m_last = 1'b1; m_rdata = '0;
    endtask

    task automatic test_write();
        int extra_acks;
        bif.wr0 = 1; bif.addr0 = 8'd3; bif.wdata0 = 16'h000C; bif.req0 = 1;
        do_txn(1);
        tests++;
        if ({o_wrc, o_rdc, o_wen} !== 3'b101) begin
            fails++; $display("FAIL t1_cmd: got wr/rd/en %b want 101", {o_wrc, o_rdc, o_wen});
        end
        tests++;
        if (o_addr !== 8'd3 || o_wdata !== 16'h000C) begin
            fails++; $display("FAIL t1_bus: got addr %0h data %0h want 3 000c", o_addr, o_wdata);
        end
        tests++;
        if ({o_ack0, o_ack1, o_err} !== 3'b100) begin
            fails++; $display("FAIL t1_ack: got ack0/ack1/err %b want 100", {o_ack0, o_ack1, o_err});
        end
        tests++;
        if ((ack_c - cmd_c) !== 2 || n_cmd !== 1) begin
            fails++; $display("FAIL t1_latency: got %0d cycles %0d cmds want 2 cycles 1 cmd", ack_c - cmd_c, n_cmd);
        end
        ref_mem[3] = 16'h000C; m_last = 1'b0;
        extra_acks = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bif.ack0 || bif.ack1) extra_acks++;
        end
        tests++;
        if (extra_acks !== 0 || bif.busy !== 1'b0) begin
            fails++; $display("FAIL t1_after: got %0d acks busy %b want 0 acks busy 0", extra_acks, bif.busy);
        end
    endtask

    task automatic test_read();
        bif.wr1 = 0; bif.addr1 = 8'd3; bif.req1 = 1;
        do_txn(1);
        m_rdata = ref_mem[3]; m_last = 1'b1;
        tests++;
        if ({o_rdc, o_wrc, o_wen} !== 3'b100 || o_addr !== 8'd3) begin
            fails++; $display("FAIL t2_cmd: got rd/wr/en %b addr %0h want 100 addr 3", {o_rdc, o_wrc, o_wen}, o_addr);
        end
        tests++;
        if ({o_ack0, o_ack1, o_err, o_gnt} !== 4'b0101) begin
            fails++; $display("FAIL t2_ack: got ack0/ack1/err/gnt %b want 0101", {o_ack0, o_ack1, o_err, o_gnt});
        end
        tests++;
        if (o_rdata !== m_rdata) begin
            fails++; $display("FAIL t2_rdata: got %0h want %0h", o_rdata, m_rdata);
        end
    endtask

    task automatic test_contention();
        logic          exp_g;
        logic [DW-1:0] wd0;
        rst = 1'b0; bif.req0 = 0; bif.req1 = 0; bif.rdyMem = 0;
        step(); step();
        rst = 1'b1;
        m_last = 1'b1; m_rdata = '0;
        wd0 = DW'($urandom);
        bif.req0 = 1; bif.wr0 = 1; bif.addr0 = 8'd10;  bif.wdata0 = wd0;
        bif.req1 = 1; bif.wr1 = 0; bif.addr1 = 8'd255;
        for (int t = 0; t < 4; t++) begin
            exp_g = ~m_last;
            do_txn(1 + (t % 2));
            if (exp_g) m_rdata = ref_mem[255];
            else       ref_mem[10] = wd0;
            tests++;
            if (o_gnt !== exp_g || {o_ack0, o_ack1} !== {~exp_g, exp_g}) begin
                fails++; $display("FAIL t3_grant%0d: got gnt %b acks %b want gnt %b", t, o_gnt, {o_ack0, o_ack1}, exp_g);
            end
            tests++;
            if (n_cmd !== 1 || o_addr !== (exp_g ? 8'd255 : 8'd10)) begin
                fails++; $display("FAIL t3_cmd%0d: got %0d cmds addr %0h", t, n_cmd, o_addr);
            end
            tests++;
            if (o_rdata !== m_rdata) begin
                fails++; $display("FAIL t3_rdata%0d: got %0h want %0h", t, o_rdata, m_rdata);
            end
            m_last = exp_g;
            if (exp_g) begin
                bif.req1 = 1; bif.wr1 = 0; bif.addr1 = 8'd255;
            end else begin
                wd0 = DW'($urandom);
                bif.req0 = 1; bif.wr0 = 1; bif.addr0 = 8'd10; bif.wdata0 = wd0;
            end
        end
        bif.req0 = 0; bif.req1 = 0;
        step(); step();
    endtask

    task automatic test_timeout();
        bif.req0 = 1; bif.wr0 = 0; bif.addr0 = 8'd3;
        do_txn(1);
        m_rdata = ref_mem[3]; m_last = 1'b0;
        bif.req0 = 1; bif.wr0 = 0; bif.addr0 = 8'd20;
        do_txn(-1);
        m_last = 1'b0;
        tests++;
        if ((ack_c - cmd_c) !== TIMEOUT + 1) begin
            fails++; $display("FAIL t4_wait_len: got %0d want %0d", ack_c - cmd_c, TIMEOUT + 1);
        end
        tests++;
        if ({o_ack0, o_err} !== 2'b11) begin
            fails++; $display("FAIL t4_err: got ack0/err %b want 11", {o_ack0, o_err});
        end
        tests++;
        if (o_rdata !== m_rdata) begin
            fails++; $display("FAIL t4_rdata_hold: got %0h want %0h", o_rdata, m_rdata);
        end
        bif.req1 = 1; bif.wr1 = 1; bif.addr1 = 8'd50; bif.wdata1 = 16'hBEEF;
        do_txn(1);
        ref_mem[50] = 16'hBEEF; m_last = 1'b1;
        tests++;
        if ((ack_c - cmd_c) !== 2 || {o_ack1, o_err} !== 2'b10) begin
            fails++; $display("FAIL t4_recover: got %0d cycles ack1/err %b want 2 10", ack_c - cmd_c, {o_ack1, o_err});
        end
    endtask

    task automatic test_rdy_boundary();
        bif.req0 = 1; bif.wr0 = 0; bif.addr0 = 8'd50;
        do_txn(TIMEOUT);
        m_rdata = ref_mem[50]; m_last = 1'b0;
        tests++;
        if ((ack_c - cmd_c) !== TIMEOUT + 1 || o_err !== 1'b0) begin
            fails++; $display("FAIL t6_last_cycle: got %0d cycles err %b want %0d err 0", ack_c - cmd_c, o_err, TIMEOUT + 1);
        end
        tests++;
        if (o_rdata !== m_rdata) begin
            fails++; $display("FAIL t6_rdata: got %0h want %0h", o_rdata, m_rdata);
        end
    endtask

    task automatic test_random();
        logic          exp_g, exp_wr, ok;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        int            d, r, exp_lat, prev_cmd;
        prev_cmd = -1;
        for (int it = 0; it < 30; it++) begin
            if (!bif.req0 && $urandom_range(0, 2) != 0) begin
                bif.req0 = 1; bif.wr0 = 1'($urandom); bif.addr0 = AW'($urandom); bif.wdata0 = DW'($urandom);
            end
            if (!bif.req1 && $urandom_range(0, 2) != 0) begin
                bif.req1 = 1; bif.wr1 = 1'($urandom); bif.addr1 = AW'($urandom); bif.wdata1 = DW'($urandom);
            end
            if (!bif.req0 && !bif.req1) begin
                bif.req0 = 1; bif.wr0 = 1'($urandom); bif.addr0 = AW'($urandom); bif.wdata0 = DW'($urandom);
            end
            exp_g    = (bif.req0 && bif.req1) ? ~m_last : bif.req1;
            exp_wr   = exp_g ? bif.wr1 : bif.wr0;
            exp_addr = exp_g ? bif.addr1 : bif.addr0;
            exp_wd   = exp_g ? bif.wdata1 : bif.wdata0;
            r = $urandom_range(0, 9);
            d = (r == 0) ? -1 : ((r == 1) ? TIMEOUT : $urandom_range(1, 4));
            ok = (d >= 1 && d <= TIMEOUT);
            exp_lat = ok ? d + 1 : TIMEOUT + 1;
            do_txn(d);
            if (ok) begin
                if (exp_wr) ref_mem[exp_addr] = exp_wd;
                else        m_rdata = ref_mem[exp_addr];
            end
            tests++;
            if (o_gnt !== exp_g || {o_ack0, o_ack1} !== {~exp_g, exp_g} || n_cmd !== 1) begin
                fails++; $display("FAIL rnd_grant%0d: got gnt %b acks %b cmds %0d want gnt %b", it, o_gnt, {o_ack0, o_ack1}, n_cmd, exp_g);
            end
            tests++;
            if ({o_wrc, o_rdc, o_wen} !== {exp_wr, ~exp_wr, exp_wr} || o_addr !== exp_addr || (exp_wr && o_wdata !== exp_wd)) begin
                fails++; $display("FAIL rnd_cmd%0d: got wr/rd/en %b addr %0h data %0h want wr %b addr %0h data %0h",
                                  it, {o_wrc, o_rdc, o_wen}, o_addr, o_wdata, exp_wr, exp_addr, exp_wd);
            end
            tests++;
            if ((ack_c - cmd_c) !== exp_lat || o_err !== ~ok) begin
                fails++; $display("FAIL rnd_timing%0d: got %0d cycles err %b want %0d err %b", it, ack_c - cmd_c, o_err, exp_lat, ~ok);
            end
            tests++;
            if (o_rdata !== m_rdata) begin
                fails++; $display("FAIL rnd_rdata%0d: got %0h want %0h", it, o_rdata, m_rdata);
            end
            if (prev_cmd >= 0) begin
                tests++;
                if ((cmd_c - prev_cmd) < 4) begin
                    fails++; $display("FAIL rnd_gap%0d: got %0d want >= 4", it, cmd_c - prev_cmd);
                end
            end
            prev_cmd = cmd_c;
            m_last = exp_g;
        end
        bif.req0 = 0; bif.req1 = 0;
        step(); step();
    endtask

    task automatic test_async_reset();
        int found, acks;
        bif.req0 = 1; bif.wr0 = 1; bif.addr0 = 8'd7; bif.wdata0 = 16'h1234;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            step();
            if (bif.writeMem) found = 1;
        end
        tests++;
        if (found !== 1) begin
            fails++; $display("FAIL t5_cmd: got no writeMem want one");
        end
        step(); step(); step();
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({bif.ack0, bif.ack1, bif.err, bif.busy, bif.gnt_id, bif.readMem, bif.writeMem, bif.memWdataEn} !== 8'h00) begin
            fails++;
            $display("FAIL t5_flags: got %b want 00000000",
                     {bif.ack0, bif.ack1, bif.err, bif.busy, bif.gnt_id, bif.readMem, bif.writeMem, bif.memWdataEn});
        end
        tests++;
        if ({bif.addrBus, bif.memWdata, bif.rdata} !== '0) begin
            fails++; $display("FAIL t5_buses: addr %0h wdata %0h rdata %0h want 0", bif.addrBus, bif.memWdata, bif.rdata);
        end
        bif.req0 = 0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) rst = 1'b1;
            step();
            if (bif.ack0 || bif.ack1) acks++;
        end
        tests++;
        if (acks !== 0) begin
            fails++; $display("FAIL t5_no_ack: got %0d acks want 0", acks);
        end
        m_last = 1'b1; m_rdata = '0;
        bif.req0 = 1; bif.wr0 = 0; bif.addr0 = 8'd3;
        bif.req1 = 1; bif.wr1 = 0; bif.addr1 = 8'd50;
        do_txn(1);
        m_rdata = ref_mem[3];
        tests++;
        if (o_gnt !== 1'b0 || o_rdata !== m_rdata) begin
            fails++; $display("FAIL t5_first_grant: got gnt %b rdata %0h want gnt 0 rdata %0h", o_gnt, o_rdata, m_rdata);
        end
        do_txn(1);
        m_rdata = ref_mem[50];
        tests++;
        if (o_gnt !== 1'b1 || o_rdata !== m_rdata) begin
            fails++; $display("FAIL t5_second_grant: got gnt %b rdata %0h want gnt 1 rdata %0h", o_gnt, o_rdata, m_rdata);
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_timeout();
        test_rdy_boundary();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
